dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: loader/debug master.
- Fixed priority to port 0, with a starvation guard that boosts port 1 after STARVE_MAX lost cycles.
- Issues at most one memory access per cycle and returns read data one cycle after grant.
- Sits between the requesters and the DataMemory instance; drives its memWrite/memRead/address/writeData.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 10, word-address width (memory depth 2**ADDR_W).
- STARVE_MAX, 4, consecutive lost cycles for port 1 before it is boosted; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 granted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (registered).
- rdata0  out  DATA_W  port 0 read data (registered).
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.
- boost  out  1  high while the FSM is in BOOST (debug).

Behaviour:
- Reset (async, rst=1):
  - rvalid0/1=0, rdata0/1=0, starve_cnt=0, FSM=NORMAL, boost=0.
  - gnt0/1=0 and mem_write/mem_read=0 while rst is high.
- FSM states:
  - NORMAL: port 0 wins when both request.
  - BOOST: port 1 wins when both request.
- Grant, combinational:
  - winner = sole requester, or the priority port per state when both request; none when neither requests.
  - gnt of the winner = 1, the other = 0. Never both 1.
- Memory strobes, combinational in the grant cycle:
  - mem_addr/mem_wdata = the winner's addr/wdata.
  - mem_write = winner.we; mem_read = winner && !winner.we.
  - No winner: mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- Write: committed at the grant-cycle rising edge; no response.
- Read, latency 1:
  - At the grant-cycle edge, rdataN <= mem_rdata and rvalidN <= 1.
  - rvalidN is a one-cycle pulse; it is cleared on the next edge unless a new read to port N is granted.
  - rdataN holds its last value when rvalidN=0.
- Back-to-back grants to the same port: allowed every cycle; rvalid stays high across consecutive reads.
- Starvation counter, 4 bits:
  - Increments on each edge where req1 && !gnt1, saturating at STARVE_MAX.
  - Cleared on gnt1, or on any edge with req1=0.
- FSM transitions:
  - NORMAL -> BOOST on the edge where starve_cnt reaches STARVE_MAX. Port 1 wins the following cycle.
  - BOOST -> NORMAL on the edge where gnt1=1, or where req1=0.
- Requester contract:
  - Holds req/we/addr/wdata stable until gnt.
  - Dropping req before gnt is permitted: no access occurs and no state is corrupted.
- Simultaneous read and write to the same address by different ports: serialized by grant order. The later access sees the earlier write.
- Reset asserted mid-read: the pending rvalid is discarded; no pulse after reset release.

Optional Feature:
- DMEM_ARB_PERF_EN
  - Defined: adds outputs grant_cnt0, grant_cnt1, conflict_cnt, each 32-bit wrapping counters.
    - grant_cnt0/1 increment on grants to the respective port.
    - conflict_cnt increments on cycles where req0 && req1.
    - All three reset to 0.
  - Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_e {NORMAL, BOOST}.
  - typedef mem_req_t {we, addr, wdata}.
  - localparam default STARVE_MAX.
  - constant PORT_PIPE=0, PORT_LOAD=1.
- Sub-module dmem_arb_starve: starvation counter plus FSM, outputs boost. Grant and datapath muxing stay in the top.

Test Plan:
- Reset, then port 0 writes 0x19 to addr 0 and reads addr 0 -> gnt0=1 both cycles; rvalid0=1 one cycle after the read grant with rdata0=0x19.
- Both request continuously, STARVE_MAX=4 -> gnt0 for 4 cycles, boost=1, gnt1 on cycle 5; then NORMAL and gnt0 resumes.
- Port 1 writes 0xF to addr 1 while port 0 reads addr 1 in the same cycle -> port 0 is granted first and returns the old value 0; port 0's re-read after port 1's grant returns 0xF.
- Port 0 reads addrs 2, 3, 4 back-to-back -> rvalid0 high 3 consecutive cycles with the matching data; mem_read never coincides with mem_write.
- rst asserted on the cycle after a port 1 read grant -> rvalid1 stays 0 through and after reset; starve_cnt=0; boost=0.
- Port 1 requests 3 cycles under contention then drops req1 -> starve_cnt clears, no BOOST entry, no port 1 access issued.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;
   localparam int STARVE_MAX_DEF = 4;
   localparam int CNT_W          = 4;
   localparam int DATA_W_DEF     = 32;
   localparam int ADDR_W_DEF     = 10;
   localparam int PORT_PIPE      = 0;
   localparam int PORT_LOAD      = 1;
   typedef enum logic {NORMAL, BOOST} arb_state_e;
   // Default-width request record; the top re-declares it at its own parameter widths.
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;
endpackage

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: port-1 starvation counter and NORMAL/BOOST priority FSM.
module dmem_arb_starve
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req1_i,
   input  logic gnt1_i,
   output logic boost_o
);
   localparam logic [CNT_W-1:0] SAT = CNT_W'(STARVE_MAX);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   arb_state_e       state_q, state_d;
   always_comb cnt_d = (!req1_i || gnt1_i) ? '0 : (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= NORMAL;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end
   // Boost on the edge the count reaches its limit; leave once port 1 is served or gives up.
   always_comb begin
      state_d = state_q;
      if (state_q == NORMAL && cnt_d == SAT)
         state_d = BOOST;
      else if (state_q == BOOST && (gnt1_i || !req1_i))
         state_d = NORMAL;
   end
   always_comb boost_o = (state_q == BOOST);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the MEM stage and a loader port.
// Define DMEM_ARB_PERF_EN to add grant and conflict performance counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              boost
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       grant_cnt0,
   output logic [31:0]       grant_cnt1,
   output logic [31:0]       conflict_cnt
`endif
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;
   req_t              p0_w, p1_w, win_w;
   logic [1:0]        gnt_w;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk     (clk),
      .rst     (rst),
      .req1_i  (req1),
      .gnt1_i  (gnt_w[PORT_LOAD]),
      .boost_o (boost)
   );
   always_comb begin
      p0_w             = '{we: we0, addr: addr0, wdata: wdata0};
      p1_w             = '{we: we1, addr: addr1, wdata: wdata1};
      gnt_w            = '0;
      gnt_w[PORT_LOAD] = !rst && req1 && (!req0 || boost);
      gnt_w[PORT_PIPE] = !rst && req0 && !gnt_w[PORT_LOAD];
      win_w            = gnt_w[PORT_LOAD] ? p1_w : gnt_w[PORT_PIPE] ? p0_w : '0;
      gnt0             = gnt_w[PORT_PIPE];
      gnt1             = gnt_w[PORT_LOAD];
      mem_write        = win_w.we;
      mem_read         = (|gnt_w) && !win_w.we;
      mem_addr         = win_w.addr;
      mem_wdata        = win_w.wdata;
      rvalid0_d        = gnt_w[PORT_PIPE] && !we0;
      rvalid1_d        = gnt_w[PORT_LOAD] && !we1;
      rdata0_d         = rvalid0_d ? mem_rdata : rdata0_q;
      rdata1_d         = rvalid1_d ? mem_rdata : rdata1_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_q + 32'(gnt_w[PORT_PIPE]);
         grant_cnt1_q   <= grant_cnt1_q + 32'(gnt_w[PORT_LOAD]);
         conflict_cnt_q <= conflict_cnt_q + 32'(req0 && req1);
      end
   end
   assign grant_cnt0   = grant_cnt0_q;
   assign grant_cnt1   = grant_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif
endmodule
